// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES/Rijndael definitions for the round datapath:
//               byte type, ShiftRows mode enum and the row shift-offset
//               helper used by the permutation network.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  // Widest Rijndael block supported by the datapath, in 32-bit columns
  localparam int NB_MAX = 8;

  typedef logic [7:0] byte_t;

  // Per-block permutation direction
  typedef enum logic {
    RS_FWD = 1'b0,
    RS_INV = 1'b1
  } rs_mode_e;

  // Left-rotation amount of a state row; the 256-bit block uses a wider
  // spread on rows 2 and 3 so that columns still diffuse across all rows.
  function automatic int shift_ofs(input int nb, input int row);
    int ofs;
    case (row)
      0:       ofs = 0;
      1:       ofs = 1;
      2:       ofs = (nb == 8) ? 3 : 2;
      3:       ofs = (nb == 8) ? 4 : 3;
      default: ofs = 0;
    endcase
    return ofs;
  endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/shift_rows_perm.sv
// ============================================================================
// Module      : shift_rows_perm
// Description : Combinational ShiftRows / InvShiftRows byte permutation for
//               an NB-column Rijndael state. Pure wiring plus a 2:1 mux per
//               byte selected by the direction input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [NB*32-1:0] data,
  input  logic             inv,
  output logic [NB*32-1:0] permuted
);

  // Only the three Rijndael block widths have defined row offsets
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_perm: NB must be 4, 6 or 8 (got %0d)", NB);
  end

  rs_mode_e mode;
  assign mode = rs_mode_e'(inv);

  // Byte (c*4+r) is row r of column c. Forward takes the byte that sits
  // s(r) columns to the right; inverse takes the one s(r) columns to the left.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFS     = shift_ofs(NB, r);
      localparam int FWD_SRC = (c + OFS) % NB;
      localparam int INV_SRC = (c + NB - OFS) % NB;

      byte_t fwd_byte;
      byte_t inv_byte;

      assign fwd_byte = data[(FWD_SRC*4 + r)*8 +: 8];
      assign inv_byte = data[(INV_SRC*4 + r)*8 +: 8];

      assign permuted[(c*4 + r)*8 +: 8] = (mode == RS_INV) ? inv_byte : fwd_byte;
    end
  end

endmodule : shift_rows_perm

`default_nettype wire

// File: rtl/shift_rows_pipe.sv
// ============================================================================
// Module      : shift_rows_pipe
// Description : Registered ShiftRows / InvShiftRows stage with valid/ready
//               handshake. A main output register plus one skid register
//               give full throughput under backpressure while in_ready stays
//               a pure register output.
//               Optional build macro SHIFT_ROWS_PIPE_PERF_CNT_EN adds the
//               blk_cnt / stall_cnt performance counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NB*32-1:0]   in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NB*32-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
`ifdef SHIFT_ROWS_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        blk_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int W = NB * 32;

  // Elaboration-time parameter legality
  if (!(NB == 4 || NB == 6 || NB == 8) || NB > NB_MAX) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8 (got %0d)", NB);
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1 (got %0d)", TAG_W);
  end

  // --------------------------------------------------------------------------
  // Permutation on the input side: storage always holds transformed blocks
  // --------------------------------------------------------------------------
  logic [W-1:0] perm_data;

  shift_rows_perm #(
    .NB (NB)
  ) u_perm (
    .data     (in_data),
    .inv      (in_inv),
    .permuted (perm_data)
  );

  // --------------------------------------------------------------------------
  // Storage state
  // --------------------------------------------------------------------------
  logic             main_valid;
  logic [W-1:0]     main_data;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [W-1:0]     skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             ready_q;

  logic             main_valid_d;
  logic [W-1:0]     main_data_d;
  logic [TAG_W-1:0] main_tag_d;
  logic             skid_valid_d;
  logic [W-1:0]     skid_data_d;
  logic [TAG_W-1:0] skid_tag_d;

  logic accept;
  logic xfer;
  logic main_open;

  assign accept    = in_valid & ready_q;
  assign xfer      = main_valid & out_ready;
  // main can take a block this edge if it is empty or is being drained
  assign main_open = ~main_valid | xfer;

  // Next-state of main/skid: skid always refills main first to keep FIFO order
  always_comb begin
    main_valid_d = main_valid;
    main_data_d  = main_data;
    main_tag_d   = main_tag;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    skid_tag_d   = skid_tag;

    if (main_open) begin
      if (skid_valid) begin
        // in_ready is low whenever skid is full, so no accept competes here
        main_valid_d = 1'b1;
        main_data_d  = skid_data;
        main_tag_d   = skid_tag;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = perm_data;
        main_tag_d   = in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // main stalled: park the block in skid, in_ready drops next cycle
      skid_valid_d = 1'b1;
      skid_data_d  = perm_data;
      skid_tag_d   = in_tag;
    end
  end

  // Storage registers; reset discards every held block and holds in_ready low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      ready_q    <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
      main_data  <= main_data_d;
      main_tag   <= main_tag_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      skid_tag   <= skid_tag_d;
      ready_q    <= ~skid_valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

`ifdef SHIFT_ROWS_PIPE_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters: completed transfers and backpressured cycles
  // --------------------------------------------------------------------------
  logic [31:0] blk_cnt_q;
  logic [31:0] stall_cnt_q;

  // Free-running wrap-around counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer) begin
        blk_cnt_q <= blk_cnt_q + 32'd1;
      end
      if (main_valid & ~out_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign blk_cnt   = blk_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule : shift_rows_pipe

`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
// ============================================================================
// Module      : tb_shift_rows_pipe
// Description : Self-checking bench for shift_rows_pipe (NB=4 and NB=8
//               instances): vector table, NB=8 pattern, backpressure order,
//               random streaming scoreboard, throughput and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_rows_pipe;

  logic clk;
  logic rst_n;

  // NB=4 instance
  logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [127:0] in_data4, out_data4;
  logic [3:0]   in_tag4, out_tag4;
  // NB=8 instance
  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [255:0] in_data8, out_data8;
  logic [3:0]   in_tag8, out_tag8;
`ifdef SHIFT_ROWS_PIPE_PERF_CNT_EN
  logic [31:0]  blk_cnt4, stall_cnt4, blk_cnt8, stall_cnt8;
`endif

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .in_inv    (in_inv4),
    .in_tag    (in_tag4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .out_tag   (out_tag4)
`ifdef SHIFT_ROWS_PIPE_PERF_CNT_EN
    ,
    .blk_cnt   (blk_cnt4),
    .stall_cnt (stall_cnt4)
`endif
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .in_inv    (in_inv8),
    .in_tag    (in_tag8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8),
    .out_tag   (out_tag8)
`ifdef SHIFT_ROWS_PIPE_PERF_CNT_EN
    ,
    .blk_cnt   (blk_cnt8),
    .stall_cnt (stall_cnt8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: state as a 4 x nb byte matrix, rows rotated by plain arithmetic
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   st[4][8];
    int           s[4];
    int           src;
    logic [255:0] res;
    s[0] = 0;
    s[1] = 1;
    s[2] = (nb == 8) ? 3 : 2;
    s[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[(c*4 + r)*8 +: 8];
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - s[r] + nb) % nb) : ((c + s[r]) % nb);
        res[(c*4 + r)*8 +: 8] = st[r][src];
      end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one block and wait (bounded) until it is accepted
  task automatic send4(input logic [127:0] d, input logic inv, input logic [3:0] tag);
    int n;
    in_valid4 = 1'b1; in_data4 = d; in_inv4 = inv; in_tag4 = tag;
    n = 0;
    while (!in_ready4 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready4) check("send4_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic send8(input logic [255:0] d, input logic inv, input logic [3:0] tag);
    int n;
    in_valid8 = 1'b1; in_data8 = d; in_inv8 = inv; in_tag8 = tag;
    n = 0;
    while (!in_ready8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready8) check("send8_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  // Scoreboard state for the NB=4 streaming phases
  logic [131:0] sb_q[$];
  int           xfer_total  = 0;
  int           stall_total = 0;
  bit           hold_pending = 0;
  logic [131:0] hold_val;

  // One clock of stimulus + scoreboard; outputs are sampled before the edge
  task automatic step(input bit v, input bit rdy);
    logic [127:0] d;
    logic [255:0] e;
    logic [131:0] exp;
    logic         iv;
    logic [3:0]   t;
    d = rnd128(); iv = 1'($urandom % 2); t = 4'($urandom % 16);
    in_valid4 = v; in_data4 = d; in_inv4 = iv; in_tag4 = t; out_ready4 = rdy;
    if (hold_pending) begin
      check("hold_valid", out_valid4, 1);
      check("hold_data", {out_data4, out_tag4}, hold_val);
    end
    hold_pending = out_valid4 && !rdy;
    hold_val     = {out_data4, out_tag4};
    if (out_valid4 && rdy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {out_data4, out_tag4}, 0);
        if ({out_data4, out_tag4} == 0) check("unexpected_out_valid", out_valid4, 0);
      end else begin
        exp = sb_q.pop_front();
        check("stream_out", {out_data4, out_tag4}, exp);
      end
      xfer_total++;
    end
    if (out_valid4 && !rdy) stall_total++;
    if (v && in_ready4) begin
      e = ref_shift({128'b0, d}, 4, iv);
      sb_q.push_back({e[127:0], t});
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [127:0] data;
    logic         inv;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [127:0] d4[4];
    logic [255:0] d8, e8, inc8;
    logic         r_inv;
    int           sent, cyc, acc, xf;

    vecs[0] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 4'h1,
                128'h0B06010C_07020D08_030E0904_0F0A0500};
    vecs[1] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1, 4'h2,
                128'h0306090C_0F020508_0B0E0104_070A0D00};
    vecs[2] = '{128'h0B06010C_07020D08_030E0904_0F0A0500, 1'b1, 4'h3,
                128'h0F0E0D0C_0B0A0908_07060504_03020100};
    vecs[3] = '{128'hFFEEDDCC_BBAA9988_77665544_33221100, 1'b0, 4'hE,
                128'hBB6611CC_7722DD88_33EE9944_FFAA5500};
    vecs[4] = '{128'hFFEEDDCC_BBAA9988_77665544_33221100, 1'b1, 4'hF,
                128'h336699CC_FF225588_BBEE1144_77AADD00};

    rst_n = 1'b0;
    in_valid4 = 0; in_data4 = '0; in_inv4 = 0; in_tag4 = '0; out_ready4 = 1'b1;
    in_valid8 = 0; in_data8 = '0; in_inv8 = 0; in_tag8 = '0; out_ready8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready4, 0);
    check("rst_out_valid", out_valid4, 0);
    check("rst_out_data", out_data4, 0);
    check("rst_out_tag", out_tag4, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready4, 1);
    check("post_rst_out_valid", out_valid4, 0);

    // Table-driven NB=4 vectors, one-cycle latency with out_ready high
    for (int i = 0; i < 5; i++) begin
      send4(vecs[i].data, vecs[i].inv, vecs[i].tag);
      check($sformatf("vec%0d_valid", i), out_valid4, 1);
      check($sformatf("vec%0d_data", i), out_data4, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), out_tag4, vecs[i].tag);
    end
    @(posedge clk); #1;
    check("vec_drained", out_valid4, 0);

    // NB=8: incrementing bytes, then round-trip, then random blocks
    for (int i = 0; i < 32; i++) inc8[i*8 +: 8] = 8'(i);
    send8(inc8, 1'b0, 4'h5);
    check("nb8_fwd", out_data8, ref_shift(inc8, 8, 1'b0));
    check("nb8_col0", out_data8[31:0], 32'h130E0500);
    d8 = out_data8;
    send8(d8, 1'b1, 4'h6);
    check("nb8_roundtrip", out_data8, inc8);
    for (int i = 0; i < 4; i++) begin
      d8 = {rnd128(), rnd128()};
      r_inv = 1'($urandom % 2);
      send8(d8, r_inv, 4'(i));
      e8 = ref_shift(d8, 8, r_inv);
      check($sformatf("nb8_rand%0d", i), out_data8, e8);
    end

    // Backpressure: tags 1,2,3 with out_ready low
    out_ready4 = 1'b1; in_valid4 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) d4[i] = rnd128();
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_data4 = d4[1]; in_inv4 = 1'b0; in_tag4 = 4'd1;
    check("bp_ready_start", in_ready4, 1);
    @(posedge clk); #1;
    check("bp_ready_after1", in_ready4, 1);
    check("bp_tag1_head", out_tag4, 1);
    in_data4 = d4[2]; in_inv4 = 1'b1; in_tag4 = 4'd2;
    @(posedge clk); #1;
    check("bp_ready_drop", in_ready4, 0);
    in_data4 = d4[3]; in_inv4 = 1'b0; in_tag4 = 4'd3;
    @(posedge clk); #1;
    check("bp_ready_held", in_ready4, 0);
    check("bp_head_held", {out_data4, out_tag4}, {ref_shift({128'b0, d4[1]}, 4, 0), 4'd1});
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check("bp_out2", {out_data4, out_tag4}, {ref_shift({128'b0, d4[2]}, 4, 1), 4'd2});
    check("bp_ready_back", in_ready4, 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("bp_out3", {out_data4, out_tag4}, {ref_shift({128'b0, d4[3]}, 4, 0), 4'd3});
    @(posedge clk); #1;
    check("bp_empty", out_valid4, 0);

    // Fresh reset so counters and scoreboard start together
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete(); hold_pending = 0; xfer_total = 0; stall_total = 0;
    @(posedge clk); #1;

    // Random streaming: 100 blocks, random valid/ready
    sent = 0; cyc = 0;
    while ((sent < 100 || sb_q.size() != 0 || out_valid4) && cyc < 3000) begin
      bit v, r, will;
      v = (sent < 100) && ($urandom % 4 != 0);
      r = ($urandom % 3 != 0);
      will = v && in_ready4;
      step(v, r);
      if (will) sent++;
      cyc++;
    end
    check("stream_sent", sent, 100);
    check("stream_drained", sb_q.size(), 0);

    // Throughput with valid and ready both held high
    acc = 0; xf = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready4) acc++;
      if (out_valid4) xf++;
      step(1'b1, 1'b1);
    end
    check("tput_accepts", acc, 20);
    check("tput_xfers", xf, 19);
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 20) begin
      step(1'b0, 1'b1);
      cyc++;
    end
    check("tput_drained", sb_q.size(), 0);
`ifdef SHIFT_ROWS_PIPE_PERF_CNT_EN
    check("blk_cnt", blk_cnt4, xfer_total);
    check("stall_cnt", stall_cnt4, stall_total);
`endif

    // Reset mid-stream with both registers occupied
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    in_valid4 = 1'b0;
    check("mid_full", in_ready4, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid4, 0);
    check("mid_rst_data", out_data4, 0);
    check("mid_rst_ready", in_ready4, 0);
`ifdef SHIFT_ROWS_PIPE_PERF_CNT_EN
    check("mid_rst_blk_cnt", blk_cnt4, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete(); hold_pending = 0;
    @(posedge clk); #1;
    check("mid_post_ready", in_ready4, 1);
    check("mid_post_valid", out_valid4, 0);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check("mid_no_stale", out_valid4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_shift_rows_pipe

`default_nettype wire

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, registered successor to the combinational ShiftRows stage. Supports Rijndael block widths Nb=4/6/8, with per-transaction forward (ShiftRows) or inverse (InvShiftRows) mode. Uses a valid/ready handshake with a 2-entry skid buffer for full throughput under backpressure. Sits between SubBytes and MixColumns in the pipelined round datapath, and is reused by the decrypt path.

Parameters:
NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error ($error in generate).
TAG_W, 4, width of sideband tag carried alongside each block; minimum 1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input block valid
in_ready  output  1  block can accept input
in_data  input  NB*32  state; byte (c*4+r) at bits [(c*4+r)*8 +: 8], r=row 0..3, c=column
in_inv  input  1  0=ShiftRows, 1=InvShiftRows; sampled with in_data
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  output block valid
out_ready  input  1  downstream accepts
out_data  output  NB*32  transformed state, same byte packing
out_tag  output  TAG_W  tag of the block on out_data

Behaviour:
- Row shift offsets s(r): NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
- Forward: out[r][c] = in[r][(c+s(r)) mod NB]. Inverse: out[r][c] = in[r][(c-s(r)) mod NB]. Pure byte permutation, no arithmetic.
- Transform is applied combinationally on accept; the result is stored in the output register. Latency is 1 cycle: a block accepted at edge N is on out_data/out_valid after edge N.
- Accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Storage: output register (main) + one skid register.
- in_ready = !skid_valid. It is registered and depends on no input combinationally. It is forced 0 while rst_n is low.
- main empty, or main transferring this cycle: an accepted block goes to main.
- main full and not transferring: an accepted block goes to skid, and in_ready drops on the next cycle.
- skid full and main transfers: skid moves to main the same edge, and skid empties.
- Simultaneous accept + transfer with skid empty: the new block replaces main; no bubble, throughput is 1 block/cycle.
- Ordering is strictly FIFO. out_data/out_tag are held stable while out_valid & !out_ready. Once out_valid rises it never drops without a transfer.
- Mode is per block: mixed in_inv on consecutive blocks is legal and independent.
- Reset (async assert, sync-safe deassert handled upstream) gives: out_valid=0, out_data=0, out_tag=0, skid cleared, in_ready=0 during reset and 1 on the first cycle after. Reset mid-transfer discards all held blocks.
- in_data/in_tag/in_inv are ignored when in_valid=0.

Optional Feature:
Macro SHIFT_ROWS_PIPE_PERF_CNT_EN.
- Defined: adds output port blk_cnt [31:0], which counts output transfers. Reset value 0; +1 per out_valid&out_ready; wraps 0xFFFFFFFF->0. Adds output port stall_cnt [31:0], which counts cycles with out_valid & !out_ready, with the same reset and wrap rules.
- Undefined: neither port nor the counters exist. Datapath and handshake are identical.

Decomposition:
- Shared package aes_pkg: NB_MAX=8, typedef byte_t (logic [7:0]), function shift_ofs(nb, row), and the enum rs_mode_e {RS_FWD=0, RS_INV=1}.
- One sub-module, shift_rows_perm: combinational, parameter NB, inputs data + inv, output permuted data. It is instantiated once before the storage registers and can be reused by the key-schedule-free round model in the testbench.

Test Plan:
- NB=4, fwd, in_data bytes 0x00..0x0F (byte i = i), out_ready=1 -> after 1 cycle, out bytes col0..3 = {00,05,0A,0F},{04,09,0E,03},{08,0D,02,07},{0C,01,06,0B}.
- NB=4, inv, same input -> out bytes {00,0D,0A,07},{04,01,0E,0B},{08,05,02,0F},{0C,09,06,03}. Fwd output fed back with inv=1 returns the original block.
- NB=8, fwd, bytes 0x00..0x1F -> row1 shifted 1, row2 shifted 3, row3 shifted 4. For example, out col0 = {00,05,0E,13}. Compare against the shift_rows_perm reference model.
- Backpressure: 3 back-to-back blocks with tags 1,2,3 and out_ready=0 -> in_ready falls after the 2nd accept, and the 3rd is held upstream. Release out_ready -> tags out in order 1,2,3, with no drop or duplicate.
- Streaming: 100 random blocks with random in_inv, random in_valid and out_ready -> scoreboard match. With both valid/ready held at 1, throughput is 1 block/cycle.
- Reset mid-stream: assert rst_n=0 with both registers full -> out_valid=0, out_data=0 immediately (async), in_ready=0. After release, in_ready=1 and no stale block appears. With the macro defined, blk_cnt=0.
